// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard sequencer
package hazard_pkg;
  typedef enum logic [2:0] {
    CLS_NOP, CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRC, CLS_JMP, CLS_CALL, CLS_RET
  } cls_e;
  typedef enum logic [1:0] {PCS_INC, PCS_BR, PCS_JMP, PCS_RET} pcs_e;
  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_RET_POP, ST_FAULT} state_e;
  localparam logic [18:0] NOP_INSTR = '0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and flag hazard compare for the ID stage
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int RA_W = 3
) (
  input  logic [2:0]      id_class_i,
  input  logic            id_uses_rt_i,
  input  logic [RA_W-1:0] id_rs_i,
  input  logic [RA_W-1:0] id_rt_i,
  input  logic            ex_mem_read_i,
  input  logic [RA_W-1:0] ex_rt_i,
  input  logic            ex_ld_flags_i,
  output logic            stall_lu_o,
  output logic            stall_fl_o
);
  assign stall_lu_o = ex_mem_read_i && (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
  assign stall_fl_o = ex_ld_flags_i && cls_e'(id_class_i) == CLS_BRC;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for stalls, flushes, PC source and return-stack depth
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int BR_PENALTY  = 1,
  parameter int RA_W        = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mem_busy_i,
  input  logic [2:0]      id_class_i,
  input  logic            id_uses_rt_i,
  input  logic            id_br_taken_i,
  input  logic [RA_W-1:0] id_rs_i,
  input  logic [RA_W-1:0] id_rt_i,
  input  logic            ex_mem_read_i,
  input  logic [RA_W-1:0] ex_rt_i,
  input  logic            ex_ld_flags_i,
  output logic            pc_wr_o,
  output logic [1:0]      pc_src_o,
  output logic            if_id_wr_o,
  output logic            if_id_flush_o,
  output logic            id_ex_bubble_o,
  output logic            push_o,
  output logic            pop_o,
  output logic            fault_o
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int CW = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(BR_PENALTY - 1);
  localparam logic PEN = BR_PENALTY > 1;
  state_e state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cls_e cls;
  pcs_e src;
  logic stall_lu, stall_fl, redirect, ovf;
  assign cls = cls_e'(id_class_i);
  assign pc_src_o = src;
  assign fault_o = state_q == ST_FAULT;
  assign redirect = cls == CLS_JMP || cls == CLS_CALL || (cls == CLS_BRC && id_br_taken_i);
  assign ovf = (cls == CLS_CALL && depth_q == DEPTH_MAX) || (cls == CLS_RET && depth_q == '0);
  hazard_detect #(.RA_W(RA_W)) u_detect (
    .id_class_i    (id_class_i),
    .id_uses_rt_i  (id_uses_rt_i),
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rt_i       (ex_rt_i),
    .ex_ld_flags_i (ex_ld_flags_i),
    .stall_lu_o    (stall_lu),
    .stall_fl_o    (stall_fl)
  );
  // Mealy sequencing: reset forces a safe bubble, mem_busy freezes everything
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    cnt_d = cnt_q;
    pc_wr_o = 1'b0;
    src = PCS_INC;
    if_id_wr_o = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_bubble_o = 1'b0;
    push_o = 1'b0;
    pop_o = 1'b0;
    if (!rst_ni) begin
      if_id_flush_o = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (!mem_busy_i) begin
      case (state_q)
        ST_RUN: begin
          pc_wr_o = 1'b1;
          if_id_wr_o = 1'b1;
          if (ovf) begin
            state_d = ST_FAULT;
            pc_wr_o = 1'b0;
            if_id_wr_o = 1'b0;
            id_ex_bubble_o = 1'b1;
          end else if (stall_lu || stall_fl) begin
            pc_wr_o = 1'b0;
            if_id_wr_o = 1'b0;
            id_ex_bubble_o = 1'b1;
          end else if (redirect) begin
            src = cls == CLS_BRC ? PCS_BR : PCS_JMP;
            if_id_flush_o = 1'b1;
            push_o = cls == CLS_CALL;
            depth_d = depth_q + DW'(push_o);
            if (PEN) begin
              state_d = ST_FLUSH;
              cnt_d = CNT_INIT;
            end
          end else if (cls == CLS_RET) begin
            pc_wr_o = 1'b0;
            pop_o = 1'b1;
            depth_d = depth_q - DW'(1);
            if_id_flush_o = 1'b1;
            id_ex_bubble_o = 1'b1;
            state_d = ST_RET_POP;
          end
        end
        ST_RET_POP: begin
          pc_wr_o = 1'b1;
          if_id_wr_o = 1'b1;
          src = PCS_RET;
          if_id_flush_o = 1'b1;
          state_d = PEN ? ST_FLUSH : ST_RUN;
          cnt_d = CNT_INIT;
        end
        ST_FLUSH: begin
          pc_wr_o = 1'b1;
          if_id_wr_o = 1'b1;
          if_id_flush_o = 1'b1;
          cnt_d = cnt_q - CW'(1);
          state_d = cnt_q == CW'(1) ? ST_RUN : ST_FLUSH;
        end
        default: id_ex_bubble_o = 1'b1;
      endcase
    end
  end
  // State, stack depth and flush counter; reset abandons any pending pop or flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      depth_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with BR_PENALTY=3, STACK_DEPTH=8
module tb_hazard_ctrl;
  import hazard_pkg::*;
  localparam int X = -1;
  localparam int INC = 0, BR = 1, JMP = 2, RET = 3;
  typedef struct {
    string tag;
    logic [8:0] e;
    logic [8:0] m;
  } exp_t;
  logic clk = 1'b0;
  logic rst_ni, mem_busy, id_uses_rt, id_br_taken, ex_mem_read, ex_ld_flags;
  logic [2:0] id_class, id_rs, id_rt, ex_rt;
  logic pc_wr, if_id_wr, if_id_flush, id_ex_bubble, push, pop, fault;
  logic [1:0] pc_src;
  logic [8:0] obs;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [17:0] run_e, stall_e, fl_e, call_e, rst_e, flt_e, ovf_e, busy_e, retpop_e, ret_e;
  always #5 clk = ~clk;
  assign obs = {pc_wr, pc_src, if_id_wr, if_id_flush, id_ex_bubble, push, pop, fault};
  hazard_ctrl #(.STACK_DEPTH(8), .BR_PENALTY(3), .RA_W(3)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .mem_busy_i     (mem_busy),
    .id_class_i     (id_class),
    .id_uses_rt_i   (id_uses_rt),
    .id_br_taken_i  (id_br_taken),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .ex_mem_read_i  (ex_mem_read),
    .ex_rt_i        (ex_rt),
    .ex_ld_flags_i  (ex_ld_flags),
    .pc_wr_o        (pc_wr),
    .pc_src_o       (pc_src),
    .if_id_wr_o     (if_id_wr),
    .if_id_flush_o  (if_id_flush),
    .id_ex_bubble_o (id_ex_bubble),
    .push_o         (push),
    .pop_o          (pop),
    .fault_o        (fault)
  );
  // Build {expected, mask}; X leaves a field unchecked
  function automatic logic [17:0] mk(int pw, int src, int iw, int fl, int bu, int pu, int po, int fa);
    logic [8:0] e, m;
    e = '0;
    m = '0;
    if (pw >= 0) begin e[8] = pw[0]; m[8] = 1'b1; end
    if (src >= 0) begin e[7:6] = src[1:0]; m[7:6] = 2'b11; end
    if (iw >= 0) begin e[5] = iw[0]; m[5] = 1'b1; end
    if (fl >= 0) begin e[4] = fl[0]; m[4] = 1'b1; end
    if (bu >= 0) begin e[3] = bu[0]; m[3] = 1'b1; end
    if (pu >= 0) begin e[2] = pu[0]; m[2] = 1'b1; end
    if (po >= 0) begin e[1] = po[0]; m[1] = 1'b1; end
    if (fa >= 0) begin e[0] = fa[0]; m[0] = 1'b1; end
    return {e, m};
  endfunction
  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (pc_wr,pc_src,if_id_wr,flush,bubble,push,pop,fault)", tag, got, exp);
    end
  endtask
  task automatic idle();
    id_class = CLS_NOP;
    id_uses_rt = 1'b0;
    id_br_taken = 1'b0;
    id_rs = 3'd0;
    id_rt = 3'd0;
    ex_mem_read = 1'b0;
    ex_rt = 3'd7;
    ex_ld_flags = 1'b0;
    mem_busy = 1'b0;
  endtask
  task automatic cyc(input string tag, input logic [17:0] em);
    exp_t x;
    sb.push_back('{tag, em[17:9], em[8:0]});
    @(negedge clk);
    x = sb.pop_front();
    check(x.tag, obs & x.m, x.e & x.m);
    @(posedge clk);
    #1;
  endtask
  task automatic do_call(input string tag);
    id_class = CLS_CALL;
    cyc(tag, call_e);
    idle();
    cyc({tag, "_f1"}, fl_e);
    cyc({tag, "_f2"}, fl_e);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    run_e = mk(1, INC, 1, 0, 0, 0, 0, 0);
    stall_e = mk(0, X, 0, 0, 1, 0, 0, 0);
    fl_e = mk(1, X, X, 1, X, 0, 0, 0);
    call_e = mk(1, JMP, X, 1, 0, 1, 0, 0);
    rst_e = mk(0, INC, 0, 1, 1, 0, 0, 0);
    flt_e = mk(0, X, 0, X, 1, 0, 0, 1);
    ovf_e = mk(0, X, X, X, 1, 0, 0, 0);
    busy_e = mk(0, X, 0, X, 0, 0, 0, 0);
    retpop_e = mk(1, RET, X, 1, 0, 0, 0, 0);
    ret_e = mk(0, X, X, 1, 1, 0, 1, 0);
    rst_ni = 1'b0;
    idle();
    @(posedge clk);
    #1;
    cyc("rst", rst_e);
    rst_ni = 1'b1;
    cyc("idle", run_e);
    id_class = CLS_ALU; id_rs = 3'd3; ex_mem_read = 1'b1; ex_rt = 3'd3;
    cyc("lu_rs", stall_e);
    ex_mem_read = 1'b0;
    cyc("lu_after", run_e);
    id_rs = 3'd2; id_rt = 3'd3; id_uses_rt = 1'b0; ex_mem_read = 1'b1;
    cyc("lu_no_rt", run_e);
    id_uses_rt = 1'b1;
    cyc("lu_rt", stall_e);
    mem_busy = 1'b1;
    cyc("busy_run", busy_e);
    idle();
    id_class = CLS_BRC; id_br_taken = 1'b1; ex_ld_flags = 1'b1;
    cyc("fl_stall", stall_e);
    ex_ld_flags = 1'b0;
    cyc("br_taken", mk(1, BR, X, 1, 0, 0, 0, 0));
    idle();
    id_class = CLS_CALL; ex_mem_read = 1'b1; ex_rt = 3'd0;
    cyc("br_f1", fl_e);
    cyc("br_f2", fl_e);
    idle();
    cyc("br_run", run_e);
    id_class = CLS_BRC;
    cyc("br_not_taken", run_e);
    id_class = CLS_JMP;
    cyc("jmp", mk(1, JMP, X, 1, 0, 0, 0, 0));
    cyc("jmp_f1", fl_e);
    cyc("jmp_f2", fl_e);
    idle();
    cyc("jmp_run", run_e);
    for (int i = 0; i < 8; i++) do_call($sformatf("call%0d", i));
    id_class = CLS_CALL;
    cyc("call_ovf", ovf_e);
    for (int i = 0; i < 3; i++) cyc("fault_hold", flt_e);
    rst_ni = 1'b0;
    cyc("rst_fault", rst_e);
    rst_ni = 1'b1;
    idle();
    cyc("post_rst", run_e);
    do_call("c1");
    id_class = CLS_RET;
    cyc("ret", ret_e);
    idle();
    cyc("ret_pop", retpop_e);
    cyc("ret_f1", fl_e);
    cyc("ret_f2", fl_e);
    id_class = CLS_RET;
    cyc("ret_unf", ovf_e);
    idle();
    cyc("unf_fault", flt_e);
    rst_ni = 1'b0;
    cyc("rst_unf", rst_e);
    rst_ni = 1'b1;
    do_call("c2");
    id_class = CLS_RET;
    cyc("ret2", ret_e);
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc("busy_retpop", busy_e);
    mem_busy = 1'b0;
    cyc("ret_pop2", retpop_e);
    cyc("ret2_f1", fl_e);
    cyc("ret2_f2", fl_e);
    cyc("ret2_run", run_e);
    id_class = CLS_CALL;
    cyc("c3", call_e);
    idle();
    cyc("c3_f1", fl_e);
    rst_ni = 1'b0;
    cyc("rst_mid_flush", rst_e);
    rst_ni = 1'b1;
    cyc("after_mid_rst", run_e);
    id_class = CLS_RET;
    cyc("ret_after_rst", ovf_e);
    idle();
    cyc("final_fault", flt_e);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
